// File: rtl/bsg_clkbuf_gate_ctrl_if.sv
// Activity-in / clock-enable-out bundle shared between the gating controller
// and whatever produces the per-domain busy requests.
interface bsg_clkbuf_gate_ctrl_if #(
   parameter int channels_p = 4
);
   logic [channels_p-1:0] busy_i;
   logic                  force_on_i;
   logic [channels_p-1:0] en_o;
   logic [channels_p-1:0] awake_o;
   logic                  any_en_o;

   modport master (
      output busy_i,
      output force_on_i,
      input  en_o,
      input  awake_o,
      input  any_en_o
   );

   modport slave (
      input  busy_i,
      input  force_on_i,
      output en_o,
      output awake_o,
      output any_en_o
   );
endinterface

// File: rtl/bsg_clkbuf_gate_ctrl.sv
// Per-channel clock-enable controller: drops a channel's enable after a run of
// idle cycles and brings it back through a fixed-length settle sequence.
module bsg_clkbuf_gate_ctrl #(
   parameter int channels_p    = 4,
   parameter int idle_cycles_p = 8,
   parameter int wake_cycles_p = 2
) (
   input logic                    clk_i,
   input logic                    reset_i,
   bsg_clkbuf_gate_ctrl_if.slave  bus
);

   localparam int IW = $clog2(idle_cycles_p + 1);
   localparam int WW = (wake_cycles_p > 0) ? $clog2(wake_cycles_p + 1) : 1;
   localparam logic [IW-1:0] IDLE_LOAD = IW'(idle_cycles_p);
   localparam logic [WW-1:0] WAKE_LOAD = WW'(wake_cycles_p);

   typedef enum logic [1:0] {
      ST_ON   = 2'd0,
      ST_OFF  = 2'd1,
      ST_WAKE = 2'd2
   } state_e;

   logic [channels_p-1:0] en;
   logic [channels_p-1:0] awake;

   for (genvar ch = 0; ch < channels_p; ch++) begin : g_ch
      state_e          state;
      state_e          state_next;
      logic [IW-1:0]   idle_cnt;
      logic [IW-1:0]   idle_next;
      logic [WW-1:0]   wake_cnt;
      logic [WW-1:0]   wake_next;
      logic            act;

      assign act = bus.busy_i[ch] | bus.force_on_i;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            state    <= ST_ON;
            idle_cnt <= IDLE_LOAD;
            wake_cnt <= '0;
         end else begin
            state    <= state_next;
            idle_cnt <= idle_next;
            wake_cnt <= wake_next;
         end
      end

      always_comb begin
         state_next = state;
         idle_next  = idle_cnt;
         wake_next  = wake_cnt;
         case (state)
            ST_ON: begin
               if (act) begin
                  idle_next = IDLE_LOAD;
               end else if (idle_cnt == IW'(1)) begin
                  state_next = ST_OFF;
               end else begin
                  idle_next = idle_cnt - IW'(1);
               end
            end
            ST_OFF: begin
               if (act) begin
                  // With no settle time the channel is usable on the very next cycle.
                  if (wake_cycles_p > 0) begin
                     state_next = ST_WAKE;
                     wake_next  = WAKE_LOAD;
                  end else begin
                     state_next = ST_ON;
                     idle_next  = IDLE_LOAD;
                  end
               end
            end
            ST_WAKE: begin
               if (wake_cnt == WW'(1)) begin
                  state_next = ST_ON;
                  idle_next  = IDLE_LOAD;
               end else begin
                  wake_next = wake_cnt - WW'(1);
               end
            end
            default: begin
               state_next = ST_ON;
               idle_next  = IDLE_LOAD;
               wake_next  = '0;
            end
         endcase
      end

      assign en[ch]    = (state != ST_OFF);
      assign awake[ch] = (state == ST_ON);
   end

   assign bus.en_o     = en;
   assign bus.awake_o  = awake;
   assign bus.any_en_o = |en;

`ifndef SYNTHESIS
   param_ok: assert property (@(posedge clk_i) (idle_cycles_p >= 1) && (channels_p >= 1));
   inputs_known: assert property (@(posedge clk_i) disable iff (reset_i)
      !$isunknown({bus.busy_i, bus.force_on_i}));
`endif

endmodule

// File: tb/tb_bsg_clkbuf_gate_ctrl.sv
// Bench for bsg_clkbuf_gate_ctrl: two instances (default and wake=0/idle=1)
// checked cycle by cycle against a behavioural model through a scoreboard queue.
module tb_bsg_clkbuf_gate_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bsg_clkbuf_gate_ctrl_if #(.channels_p(4)) bus_a ();
   bsg_clkbuf_gate_ctrl_if #(.channels_p(2)) bus_b ();

   bsg_clkbuf_gate_ctrl #(.channels_p(4), .idle_cycles_p(8), .wake_cycles_p(2)) dut_a (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus_a.slave)
   );

   bsg_clkbuf_gate_ctrl #(.channels_p(2), .idle_cycles_p(1), .wake_cycles_p(0)) dut_b (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus_b.slave)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // expected/observed packing: {en_a, awake_a, any_a, en_b, awake_b, any_b}
   logic [13:0] sb [$];

   logic a_off  [4];
   int   a_idle [4];
   int   a_wake [4];
   logic b_off  [2];
   int   b_idle [2];
   int   b_wake [2];

   // Model state: off flag, consecutive idle samples seen while on, settle cycles left.
   task automatic model_ch(input logic r, input logic act, input int lim_idle, input int lim_wake,
                           input logic off_in, input int idle_in, input int wake_in,
                           output logic off_out, output int idle_out, output int wake_out);
      off_out  = off_in;
      idle_out = idle_in;
      wake_out = wake_in;
      if (r) begin
         off_out = 1'b0; idle_out = 0; wake_out = 0;
      end else if (wake_in > 0) begin
         wake_out = wake_in - 1;
         idle_out = 0;
      end else if (off_in) begin
         if (act) begin
            off_out  = 1'b0;
            idle_out = 0;
            wake_out = lim_wake;
         end
      end else if (act) begin
         idle_out = 0;
      end else begin
         idle_out = idle_in + 1;
         if (idle_out == lim_idle) off_out = 1'b1;
      end
   endtask

   task automatic step(input logic r, input logic [3:0] ba, input logic fa,
                       input logic [1:0] bb, input logic fb);
      logic [3:0] ea, wa;
      logic [1:0] eb, wb;
      rst = r;
      bus_a.busy_i = ba; bus_a.force_on_i = fa;
      bus_b.busy_i = bb; bus_b.force_on_i = fb;
      for (int c = 0; c < 4; c++)
         model_ch(r, ba[c] | fa, 8, 2, a_off[c], a_idle[c], a_wake[c], a_off[c], a_idle[c], a_wake[c]);
      for (int c = 0; c < 2; c++)
         model_ch(r, bb[c] | fb, 1, 0, b_off[c], b_idle[c], b_wake[c], b_off[c], b_idle[c], b_wake[c]);
      for (int c = 0; c < 4; c++) begin
         ea[c] = !a_off[c];
         wa[c] = !a_off[c] && (a_wake[c] == 0);
      end
      for (int c = 0; c < 2; c++) begin
         eb[c] = !b_off[c];
         wb[c] = !b_off[c] && (b_wake[c] == 0);
      end
      sb.push_back({ea, wa, |ea, eb, wb, |eb});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [13:0] observe();
      return {bus_a.en_o, bus_a.awake_o, bus_a.any_en_o, bus_b.en_o, bus_b.awake_o, bus_b.any_en_o};
   endfunction

   task automatic test_reset();
      logic [13:0] exp_v, obs_v;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 4'h0, 1'b0, 2'b00, 1'b0);
         exp_v = sb.pop_front();
         obs_v = observe();
         n_cmp++;
         if (obs_v !== exp_v || obs_v !== 14'h3FFF) begin
            n_fail++;
            $display("FAIL reset cyc=%0d got=%h expected=%h", cyc, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_idle_drop();
      logic [13:0] exp_v, obs_v;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 4'h0, 1'b0, 2'b00, 1'b0);
         exp_v = sb.pop_front();
         obs_v = observe();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL idle_drop step=%0d got=%h expected=%h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_countdown_restart();
      logic [13:0] exp_v, obs_v;
      step(1'b1, 4'h0, 1'b0, 2'b00, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 18; i++) begin
         step(1'b0, (i == 7) ? 4'b0001 : 4'b0000, 1'b0, 2'b00, 1'b0);
         exp_v = sb.pop_front();
         obs_v = observe();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL countdown_restart step=%0d got=%h expected=%h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_wake();
      logic [13:0] exp_v, obs_v;
      for (int i = 0; i < 13; i++) begin
         step(1'b0, (i == 0) ? 4'b0010 : 4'b0000, 1'b0, 2'b00, 1'b0);
         exp_v = sb.pop_front();
         obs_v = observe();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL wake step=%0d got=%h expected=%h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_force();
      logic [13:0] exp_v, obs_v;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 4'h0, (i < 20), 2'b00, 1'b0);
         exp_v = sb.pop_front();
         obs_v = observe();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL force step=%0d got=%h expected=%h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [13:0] exp_v, obs_v;
      logic [3:0]  ba;
      logic        r;
      step(1'b1, 4'h0, 1'b0, 2'b00, 1'b0);
      void'(sb.pop_front());
      // ch3 held busy while the rest drop, then ch3 counts down to 1 as ch2 starts waking
      for (int i = 0; i < 26; i++) begin
         r  = (i == 15);
         ba = 4'b0000;
         if (i < 8) ba = 4'b1000;
         else if (i == 14) ba = 4'b0100;
         step(r, ba, 1'b0, 2'b00, 1'b0);
         exp_v = sb.pop_front();
         obs_v = observe();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid step=%0d got=%h expected=%h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_param_sweep();
      logic [13:0] exp_v, obs_v;
      logic [1:0]  pat [10] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 4'h0, 1'b0, pat[i], (i == 7));
         exp_v = sb.pop_front();
         obs_v = observe();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL param_sweep step=%0d got=%h expected=%h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [13:0] exp_v, obs_v;
      for (int i = 0; i < 80; i++) begin
         step(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
              ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3) & $urandom_range(0, 3)),
              ($urandom_range(0, 15) == 0));
         exp_v = sb.pop_front();
         obs_v = observe();
         n_cmp++;
         if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL back_to_back step=%0d got=%h expected=%h", i, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus_a.busy_i = '0; bus_a.force_on_i = 1'b0;
      bus_b.busy_i = '0; bus_b.force_on_i = 1'b0;
      for (int c = 0; c < 4; c++) begin a_off[c] = 1'b0; a_idle[c] = 0; a_wake[c] = 0; end
      for (int c = 0; c < 2; c++) begin b_off[c] = 1'b0; b_idle[c] = 0; b_wake[c] = 0; end
      test_reset();
      test_idle_drop();
      test_countdown_restart();
      test_wake();
      test_force();
      test_reset_mid();
      test_param_sweep();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
